// File: rtl/px_sobel_wnd.sv
// 3x3 Sobel window engine: fetches grey pixels column by column from a circular
// row buffer in BRAM and emits saturated |Gx|+|Gy| for every interior column.
module px_sobel_wnd #(
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int BUF_ROWS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wnd_in_bram,
    output logic        bram_rd_en,
    output logic [31:0] bram_rd_addr,
    input  logic [31:0] bram_rd_data,
    output logic [7:0]  px_out_data,
    output logic        px_out_valid,
    input  logic        px_out_ready,
    output logic        pixel_ack,
    output logic        frame_done,
    output logic        busy
);

    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW = (BUF_ROWS > 2) ? $clog2(BUF_ROWS) : 1;
    localparam int OW = (IMG_H > 2) ? $clog2(IMG_H) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        RD2,
        WAIT,
        OUT,
        ROW_END
    } state_t;

    state_t        state;
    logic [CW-1:0] col;
    logic [CW-1:0] col_nxt;
    logic [RW-1:0] row_idx;
    logic [OW-1:0] out_row;
    logic [7:0]    nc0;
    logic [7:0]    nc1;
    logic [7:0]    p      [0:2][0:2];
    logic [7:0]    w      [0:2][0:2];
    logic [7:0]    newcol [0:2];
    logic          last_row;
    logic          unused_rd_hi;

    logic signed [10:0] gx;
    logic signed [10:0] gy;
    logic [10:0]        ax;
    logic [10:0]        ay;
    logic [11:0]        sum;
    logic [7:0]         mag;

    assign unused_rd_hi = ^bram_rd_data[31:8];
    assign busy         = (state != IDLE);
    assign col_nxt      = col + CW'(1);
    assign last_row     = (out_row == OW'(IMG_H - 3));

    // Word address of window row k for a column, wrapping around the ring buffer.
    function automatic logic [31:0] row_addr(input logic [RW-1:0] r, input logic [1:0] k,
                                             input logic [CW-1:0] c);
        logic [31:0] rr;
        rr = 32'(r) + 32'(k);
        if (rr >= 32'(BUF_ROWS)) rr = rr - 32'(BUF_ROWS);
        return rr * 32'(IMG_W) + 32'(c);
    endfunction

    function automatic logic signed [10:0] ext(input logic [7:0] v);
        return signed'({3'b000, v});
    endfunction

    // Window as it will look after the WAIT shift, so the magnitude is ready on OUT entry.
    always_comb begin
        newcol[0] = nc0;
        newcol[1] = nc1;
        newcol[2] = bram_rd_data[7:0];
        for (int unsigned r = 0; r < 3; r++) begin
            w[r][0] = p[r][1];
            w[r][1] = p[r][2];
            w[r][2] = newcol[r];
        end
    end

    always_comb begin
        gx  = (ext(w[0][2]) + (ext(w[1][2]) <<< 1) + ext(w[2][2]))
            - (ext(w[0][0]) + (ext(w[1][0]) <<< 1) + ext(w[2][0]));
        gy  = (ext(w[2][0]) + (ext(w[2][1]) <<< 1) + ext(w[2][2]))
            - (ext(w[0][0]) + (ext(w[0][1]) <<< 1) + ext(w[0][2]));
        ax  = gx[10] ? 11'(-gx) : 11'(gx);
        ay  = gy[10] ? 11'(-gy) : 11'(gy);
        sum = {1'b0, ax} + {1'b0, ay};
        mag = (sum > 12'd255) ? 8'hFF : sum[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            col          <= '0;
            row_idx      <= '0;
            out_row      <= '0;
            nc0          <= '0;
            nc1          <= '0;
            bram_rd_en   <= 1'b0;
            bram_rd_addr <= '0;
            px_out_data  <= '0;
            px_out_valid <= 1'b0;
            pixel_ack    <= 1'b0;
            frame_done   <= 1'b0;
            for (int unsigned r = 0; r < 3; r++) begin
                for (int unsigned c = 0; c < 3; c++) begin
                    p[r][c] <= '0;
                end
            end
        end else begin
            pixel_ack  <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (wnd_in_bram) begin
                        state        <= RD0;
                        bram_rd_en   <= 1'b1;
                        bram_rd_addr <= row_addr(row_idx, 2'd0, col);
                    end
                end
                RD0: begin
                    state        <= RD1;
                    bram_rd_addr <= row_addr(row_idx, 2'd1, col);
                end
                RD1: begin
                    nc0          <= bram_rd_data[7:0];
                    state        <= RD2;
                    bram_rd_addr <= row_addr(row_idx, 2'd2, col);
                end
                RD2: begin
                    nc1        <= bram_rd_data[7:0];
                    state      <= WAIT;
                    bram_rd_en <= 1'b0;
                end
                WAIT: begin
                    for (int unsigned r = 0; r < 3; r++) begin
                        for (int unsigned c = 0; c < 3; c++) begin
                            p[r][c] <= w[r][c];
                        end
                    end
                    if (col >= CW'(2)) begin
                        state        <= OUT;
                        px_out_data  <= mag;
                        px_out_valid <= 1'b1;
                    end else begin
                        col          <= col_nxt;
                        state        <= RD0;
                        bram_rd_en   <= 1'b1;
                        bram_rd_addr <= row_addr(row_idx, 2'd0, col_nxt);
                    end
                end
                OUT: begin
                    if (px_out_ready) begin
                        px_out_valid <= 1'b0;
                        if (col < CW'(IMG_W - 1)) begin
                            col          <= col_nxt;
                            state        <= RD0;
                            bram_rd_en   <= 1'b1;
                            bram_rd_addr <= row_addr(row_idx, 2'd0, col_nxt);
                        end else begin
                            col        <= '0;
                            state      <= ROW_END;
                            pixel_ack  <= 1'b1;
                            frame_done <= last_row;
                        end
                    end
                end
                ROW_END: begin
                    state <= IDLE;
                    if (last_row) begin
                        out_row <= '0;
                        row_idx <= '0;
                    end else begin
                        out_row <= out_row + OW'(1);
                        row_idx <= (row_idx == RW'(BUF_ROWS - 1)) ? '0 : row_idx + RW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_px_sobel_wnd.sv
// Scoreboard bench for px_sobel_wnd on a reduced 16x12 image with an 8-row BRAM model.
module tb_px_sobel_wnd;

    localparam int IMG_W    = 16;
    localparam int IMG_H    = 12;
    localparam int BUF_ROWS = 8;
    localparam int MEM_SZ   = IMG_W * BUF_ROWS;

    logic        clk = 1'b0;
    logic        rst;
    logic        wnd_in_bram;
    logic        bram_rd_en;
    logic [31:0] bram_rd_addr;
    logic [31:0] bram_rd_data;
    logic [7:0]  px_out_data;
    logic        px_out_valid;
    logic        px_out_ready;
    logic        pixel_ack;
    logic        frame_done;
    logic        busy;

    logic [7:0] mem [MEM_SZ];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int sb[$];
    int rd_log[$];
    int ack_cnt = 0;
    int fd_cnt = 0;
    int out_cnt = 0;
    int t_rd = -1;
    int lat = -1;
    int last_addr_target = -1;
    logic prev_valid = 1'b0;
    int tb_row = 0;
    int tb_out = 0;

    always #5 clk = ~clk;

    px_sobel_wnd #(
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H),
        .BUF_ROWS (BUF_ROWS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wnd_in_bram  (wnd_in_bram),
        .bram_rd_en   (bram_rd_en),
        .bram_rd_addr (bram_rd_addr),
        .bram_rd_data (bram_rd_data),
        .px_out_data  (px_out_data),
        .px_out_valid (px_out_valid),
        .px_out_ready (px_out_ready),
        .pixel_ack    (pixel_ack),
        .frame_done   (frame_done),
        .busy         (busy)
    );

    always @(posedge clk) begin
        cyc++;
        if (bram_rd_en)
            bram_rd_data <= {24'hA5C3E1, (bram_rd_addr < 32'(MEM_SZ)) ? mem[bram_rd_addr] : 8'h00};
    end

    always @(negedge clk) begin
        int e;
        if (!rst) begin
            if (bram_rd_en) begin
                rd_log.push_back(int'(bram_rd_addr));
                if (int'(bram_rd_addr) == last_addr_target) t_rd = cyc;
            end
            if (px_out_valid && !prev_valid && t_rd >= 0) lat = cyc - t_rd;
            if (px_out_valid && px_out_ready) begin
                out_cnt++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pixel got=%0d required=none", px_out_data);
                end else begin
                    e = sb.pop_front();
                    if (px_out_data !== 8'(e)) begin
                        failures++;
                        $display("FAIL pixel got=%0d required=%0d (row_idx=%0d)", px_out_data, e, tb_row);
                    end
                end
            end
            if (pixel_ack) ack_cnt++;
            if (frame_done) fd_cnt++;
        end
        prev_valid = px_out_valid;
    end

    function automatic int sobel_ref(int r0, int c);
        int g[3][3];
        int gx, gy, m;
        for (int r = 0; r < 3; r++)
            for (int d = 0; d < 3; d++)
                g[r][d] = int'(mem[((r0 + r) % BUF_ROWS) * IMG_W + c - 1 + d]);
        gx = (g[0][2] + 2 * g[1][2] + g[2][2]) - (g[0][0] + 2 * g[1][0] + g[2][0]);
        gy = (g[2][0] + 2 * g[2][1] + g[2][2]) - (g[0][0] + 2 * g[0][1] + g[0][2]);
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (m > 255) ? 255 : m;
    endfunction

    task automatic push_row();
        for (int c = 1; c <= IMG_W - 2; c++) sb.push_back(sobel_ref(tb_row, c));
    endtask

    // Drives one row; stall>0 holds ready low for that many cycles on the first pixel.
    task automatic run_row(input int stall, output bit frame_exp);
        int n, a0, o0;
        logic [7:0] held;
        push_row();
        t_rd = -1;
        lat = -1;
        last_addr_target = tb_row * IMG_W + IMG_W - 1;
        rd_log.delete();
        a0 = ack_cnt;
        o0 = out_cnt;
        if (stall > 0) px_out_ready = 1'b0;
        @(posedge clk); #1;
        wnd_in_bram = 1'b1;
        n = 0;
        while (!busy && n < 10) begin @(posedge clk); #1; n++; end
        wnd_in_bram = 1'b0;
        if (stall > 0) begin
            n = 0;
            while (!px_out_valid && n < 200) begin @(negedge clk); n++; end
            held = px_out_data;
            checks++;
            if (!px_out_valid) begin
                failures++;
                $display("FAIL stall_wait_valid got=0 required=1");
            end
            repeat (stall) begin
                @(negedge clk);
                checks++;
                if ({px_out_valid, px_out_data, bram_rd_en} !== {1'b1, held, 1'b0}) begin
                    failures++;
                    $display("FAIL stall_hold got valid=%0b data=%0d rd_en=%0b required valid=1 data=%0d rd_en=0",
                             px_out_valid, px_out_data, bram_rd_en, held);
                end
            end
            @(posedge clk); #1;
            px_out_ready = 1'b1;
        end
        n = 0;
        while (ack_cnt == a0 && n < IMG_W * 20) begin @(posedge clk); n++; end
        checks++;
        if (ack_cnt != a0 + 1) begin
            failures++;
            $display("FAIL pixel_ack_count got=%0d required=1", ack_cnt - a0);
        end
        checks++;
        if (out_cnt - o0 != IMG_W - 2) begin
            failures++;
            $display("FAIL row_outputs got=%0d required=%0d", out_cnt - o0, IMG_W - 2);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drained got=%0d required=0", sb.size());
            sb.delete();
        end
        tb_out++;
        frame_exp = (tb_out == IMG_H - 2);
        if (frame_exp) begin
            tb_out = 0;
            tb_row = 0;
        end else begin
            tb_row = (tb_row + 1) % BUF_ROWS;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wnd_in_bram = 1'b0;
        px_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bram_rd_en, bram_rd_addr, px_out_valid, px_out_data, pixel_ack, frame_done, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got en=%0b addr=%0d v=%0b d=%0d ack=%0b fd=%0b busy=%0b required all 0",
                     bram_rd_en, bram_rd_addr, px_out_valid, px_out_data, pixel_ack, frame_done, busy);
        end
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({busy, bram_rd_en} !== 2'b00) begin
            failures++;
            $display("FAIL idle_without_wnd got busy=%0b rd_en=%0b required 0 0", busy, bram_rd_en);
        end
    endtask

    task automatic test_flat();
        bit f;
        for (int i = 0; i < MEM_SZ; i++) mem[i] = 8'd100;
        run_row(0, f);
        checks++;
        if (rd_log.size() < 3 || rd_log[0] != 0 || rd_log[1] != IMG_W || rd_log[2] != 2 * IMG_W) begin
            failures++;
            $display("FAIL first_reads got=%0d,%0d,%0d required=0,%0d,%0d",
                     rd_log.size() > 0 ? rd_log[0] : -1, rd_log.size() > 1 ? rd_log[1] : -1,
                     rd_log.size() > 2 ? rd_log[2] : -1, IMG_W, 2 * IMG_W);
        end
        checks++;
        if (lat != 4) begin
            failures++;
            $display("FAIL last_col_latency got=%0d required=4", lat);
        end
    endtask

    task automatic test_edge();
        bit f;
        for (int i = 0; i < MEM_SZ; i++) mem[i] = ((i % IMG_W) < IMG_W / 2) ? 8'd0 : 8'd200;
        checks++;
        if (sobel_ref(tb_row, IMG_W / 2) != 255 || sobel_ref(tb_row, IMG_W / 2 - 1) != 255
            || sobel_ref(tb_row, 2) != 0) begin
            failures++;
            $display("FAIL edge_model got=%0d,%0d required=255,255",
                     sobel_ref(tb_row, IMG_W / 2 - 1), sobel_ref(tb_row, IMG_W / 2));
        end
        run_row(0, f);
    endtask

    task automatic test_stall();
        bit f;
        for (int i = 0; i < MEM_SZ; i++) mem[i] = 8'($urandom_range(0, 255));
        run_row(10, f);
    endtask

    task automatic test_wrap_frame();
        bit f;
        int fd0, r;
        f = 1'b0;
        fd0 = fd_cnt;
        while (!f) begin
            for (int i = 0; i < MEM_SZ; i++) mem[i] = 8'($urandom_range(0, 255));
            r = tb_row;
            run_row(0, f);
            if (r == 6) begin
                checks++;
                if (rd_log.size() < 3 || rd_log[0] != 6 * IMG_W || rd_log[1] != 7 * IMG_W || rd_log[2] != 0) begin
                    failures++;
                    $display("FAIL wrap_reads got=%0d,%0d,%0d required=%0d,%0d,0",
                             rd_log.size() > 0 ? rd_log[0] : -1, rd_log.size() > 1 ? rd_log[1] : -1,
                             rd_log.size() > 2 ? rd_log[2] : -1, 6 * IMG_W, 7 * IMG_W);
                end
            end
            if (!f) begin
                checks++;
                if (fd_cnt != fd0) begin
                    failures++;
                    $display("FAIL early_frame_done got=%0d required=0", fd_cnt - fd0);
                end
            end
        end
        checks++;
        if (fd_cnt != fd0 + 1) begin
            failures++;
            $display("FAIL frame_done_count got=%0d required=1", fd_cnt - fd0);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_frame got busy=%0b required 0", busy);
        end
    endtask

    task automatic test_mid_reset();
        bit f;
        int n;
        for (int i = 0; i < MEM_SZ; i++) mem[i] = 8'($urandom_range(0, 255));
        push_row();
        @(posedge clk); #1;
        wnd_in_bram = 1'b1;
        n = 0;
        while (!px_out_valid && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (!px_out_valid) begin
            failures++;
            $display("FAIL mid_reset_reach_out got=0 required=1");
        end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bram_rd_en, bram_rd_addr, px_out_valid, px_out_data, pixel_ack, frame_done, busy} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs got en=%0b addr=%0d v=%0b d=%0d ack=%0b fd=%0b busy=%0b required all 0",
                     bram_rd_en, bram_rd_addr, px_out_valid, px_out_data, pixel_ack, frame_done, busy);
        end
        wnd_in_bram = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        tb_row = 0;
        tb_out = 0;
        run_row(0, f);
        checks++;
        if (rd_log.size() < 3 || rd_log[0] != 0 || rd_log[1] != IMG_W || rd_log[2] != 2 * IMG_W) begin
            failures++;
            $display("FAIL post_reset_reads got=%0d,%0d,%0d required=0,%0d,%0d",
                     rd_log.size() > 0 ? rd_log[0] : -1, rd_log.size() > 1 ? rd_log[1] : -1,
                     rd_log.size() > 2 ? rd_log[2] : -1, IMG_W, 2 * IMG_W);
        end
    endtask

    initial begin
        test_reset();
        test_flat();
        test_edge();
        test_stall();
        test_wrap_frame();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
